// File: rtl/trig_readout_pkg.sv
// Shared constants, FSM encoding and status-word helper for the trigger event readout.
package trig_readout_pkg;

    localparam logic [7:0] CMD_READ_EVENT  = 8'h01;
    localparam logic [7:0] CMD_READ_STATUS = 8'h02;

    localparam int unsigned ID_W  = 16;
    localparam int unsigned HIT_W = 24;
    localparam int unsigned TS_W  = 24;
    localparam int unsigned EVT_W = 64;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StShiftEvt,
        StShiftStat,
        StIgnore,
        StDone
    } rd_state_e;

    function automatic logic [15:0] status_word(input logic [7:0] drops, input logic [4:0] cnt);
        return {drops, 3'b000, cnt};
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-clock FIFO with a registered head peek; storage has no reset so it can map to block RAM.
module event_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
    always_comb begin
        do_pop   = pop_i & ~empty_q;
        do_push  = push_i & (~full_q | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(Depth));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
        rdata_q <= mem_q[rd_ptr_q];
    end

    assign rdata_o = rdata_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= {2{ResetVal}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/trig_event_readout.sv
// Trigger event buffer: queues {id, hits, timestamp} words and serves them to an MCU over SPI.
module trig_event_readout
    import trig_readout_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   pll_clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [ID_W-1:0]        trigger_id,
    input  logic [HIT_W-1:0]       hit_pattern,
    input  logic                   spi_clk,
    input  logic                   spi_cs,
    input  logic                   spi_si,
    output logic                   spi_so,
    output logic                   interrupt,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             sclk_s, scs_s, ssi_s;
    logic             sclk_q, scs_q;
    logic             clk_rise, clk_fall, cs_fall;
    rd_state_e        state_q, state_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [EVT_W-1:0] shreg_q, shreg_d;
    logic             out_bit_q, out_bit_d;
    logic             evt_load_q, evt_load_d;
    logic             evt_valid_q, evt_valid_d;
    logic [7:0]       drop_q, drop_d;
    logic             irq_q, so_q, so_d;
    logic             pop, stat_clr, drop;
    logic             fifo_full, fifo_empty;
    logic [EVT_W-1:0] fifo_rdata;
    logic [7:0]       cnt8;

    sync #(.ResetVal(1'b0)) u_sync_clk (.clk_i(pll_clk), .rst_ni(reset), .d_i(spi_clk), .q_o(sclk_s));
    sync #(.ResetVal(1'b1)) u_sync_cs  (.clk_i(pll_clk), .rst_ni(reset), .d_i(spi_cs),  .q_o(scs_s));
    sync #(.ResetVal(1'b0)) u_sync_si  (.clk_i(pll_clk), .rst_ni(reset), .d_i(spi_si),  .q_o(ssi_s));

    event_fifo #(
        .Depth(DEPTH),
        .Width(EVT_W)
    ) u_fifo (
        .clk_i  (pll_clk),
        .rst_ni (reset),
        .push_i (id_valid),
        .wdata_i({trigger_id, hit_pattern, ts_q}),
        .pop_i  (pop),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign clk_rise = sclk_s & ~sclk_q;
    assign clk_fall = ~sclk_s & sclk_q;
    assign cs_fall  = ~scs_s & scs_q;
    assign cnt8     = 8'(fifo_count);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        shreg_d     = shreg_q;
        out_bit_d   = out_bit_q;
        evt_load_d  = 1'b0;
        evt_valid_d = evt_valid_q;
        pop         = 1'b0;
        stat_clr    = 1'b0;
        if (scs_s) begin
            // Deselect abandons the frame; an unfinished pop or clear never happens.
            state_d     = StIdle;
            bit_cnt_d   = '0;
            out_bit_d   = 1'b0;
            evt_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                    end
                end
                StCmd: begin
                    if (clk_rise) begin
                        cmd_d     = {cmd_q[6:0], ssi_s};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_d = '0;
                            out_bit_d = 1'b0;
                            shreg_d   = '0;
                            if (cmd_d == CMD_READ_EVENT) begin
                                state_d     = StShiftEvt;
                                evt_load_d  = ~fifo_empty;
                                evt_valid_d = ~fifo_empty;
                            end else if (cmd_d == CMD_READ_STATUS) begin
                                state_d = StShiftStat;
                                shreg_d = {status_word(drop_q, cnt8[4:0]), {(EVT_W - 16){1'b0}}};
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StShiftEvt, StShiftStat: begin
                    // Head data is taken one cycle after decode, once the read port has settled.
                    if (evt_load_q) begin
                        shreg_d = fifo_rdata;
                    end
                    if (clk_fall) begin
                        out_bit_d = shreg_q[EVT_W-1];
                        shreg_d   = {shreg_q[EVT_W-2:0], 1'b0};
                    end
                    if (clk_rise) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (state_q == StShiftEvt && bit_cnt_q == 6'd63) begin
                            pop     = evt_valid_q;
                            state_d = StDone;
                        end else if (state_q == StShiftStat && bit_cnt_q == 6'd15) begin
                            stat_clr = 1'b1;
                            state_d  = StDone;
                        end
                    end
                end
                StIgnore, StDone: begin
                    out_bit_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        ts_d   = ts_q + TS_W'(1);
        drop   = id_valid & fifo_full & ~pop;
        drop_d = drop_q;
        if (stat_clr) begin
            drop_d = {7'd0, drop};
        end else if (drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        so_d = ~scs_s & out_bit_q & (state_q == StShiftEvt || state_q == StShiftStat);
    end

    always_ff @(posedge pll_clk or negedge reset) begin
        if (!reset) begin
            ts_q        <= '0;
            sclk_q      <= 1'b0;
            scs_q       <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            shreg_q     <= '0;
            out_bit_q   <= 1'b0;
            evt_load_q  <= 1'b0;
            evt_valid_q <= 1'b0;
            drop_q      <= '0;
            irq_q       <= 1'b1;
            so_q        <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            sclk_q      <= sclk_s;
            scs_q       <= scs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            shreg_q     <= shreg_d;
            out_bit_q   <= out_bit_d;
            evt_load_q  <= evt_load_d;
            evt_valid_q <= evt_valid_d;
            drop_q      <= drop_d;
            irq_q       <= fifo_empty;
            so_q        <= so_d;
        end
    end

    assign spi_so    = so_q;
    assign interrupt = irq_q;
    assign overflow  = |drop_q;

endmodule

// File: tb/tb_trig_event_readout.sv
// Directed bench for trig_event_readout with a queue-based event model checked every cycle.
module tb_trig_event_readout;
    localparam int unsigned DEPTH = 16;
    localparam int H = 8;

    logic                   pll_clk = 1'b0;
    logic                   reset;
    logic                   id_valid;
    logic [15:0]            trigger_id;
    logic [23:0]            hit_pattern;
    logic                   spi_clk, spi_cs, spi_si;
    logic                   spi_so, interrupt, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    trig_event_readout #(.DEPTH(DEPTH)) dut (
        .pll_clk    (pll_clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .trigger_id (trigger_id),
        .hit_pattern(hit_pattern),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_si     (spi_si),
        .spi_so     (spi_so),
        .interrupt  (interrupt),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 pll_clk = ~pll_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of event words, a drop counter and the timestamp as a cycle count.
    logic [63:0] mq[$];
    int unsigned tcyc;
    int          drop_m;
    bit          irq_m;
    int          pop_req_n = 0, pop_seen, pop_cd;
    int          clr_req_n = 0, clr_seen, clr_cd;
    bit          pop_now, clr_now, dropped;

    always @(posedge pll_clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            tcyc     = 0;
            drop_m   = 0;
            irq_m    = 1'b1;
            pop_seen = pop_req_n;
            clr_seen = clr_req_n;
            pop_cd   = 0;
            clr_cd   = 0;
        end else begin
            irq_m   = (mq.size() == 0);
            pop_now = (pop_cd == 1);
            clr_now = (clr_cd == 1);
            if (pop_cd > 0) pop_cd--;
            if (clr_cd > 0) clr_cd--;
            // The SPI pin edge takes effect on the third clock after it is driven.
            if (pop_req_n != pop_seen) begin pop_seen = pop_req_n; pop_cd = 2; end
            if (clr_req_n != clr_seen) begin clr_seen = clr_req_n; clr_cd = 2; end
            if (pop_now && mq.size() > 0) void'(mq.pop_front());
            dropped = 1'b0;
            if (id_valid) begin
                if (mq.size() < DEPTH) mq.push_back({trigger_id, hit_pattern, tcyc[23:0]});
                else dropped = 1'b1;
            end
            if (clr_now) drop_m = dropped ? 1 : 0;
            else if (dropped && drop_m < 255) drop_m++;
            tcyc++;
        end
    end

    int cs_hi = 0;
    always @(negedge pll_clk) begin
        if (reset) begin
            check("fifo_count", 64'(fifo_count), 64'(mq.size()));
            check("interrupt", 64'(interrupt), 64'(irq_m));
            check("overflow", 64'(overflow), 64'(drop_m != 0));
            if (cs_hi >= 4) check("so_idle", 64'(spi_so), 64'd0);
        end
        cs_hi = spi_cs ? cs_hi + 1 : 0;
    end

    bit          push_at_pop = 1'b0;
    logic [15:0] pp_id;
    logic [23:0] pp_hit;

    task automatic push(input logic [15:0] id, input logic [23:0] hit);
        id_valid    = 1'b1;
        trigger_id  = id;
        hit_pattern = hit;
        @(negedge pll_clk);
        id_valid = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int nbits, input int extra,
                             input bit hold, output logic [63:0] rx);
        logic [63:0] exp;
        exp = 64'd0;
        if (cmd == 8'h01 && mq.size() != 0) exp = mq[0];
        else if (cmd == 8'h02) exp = {8'(drop_m), 3'b000, 5'(mq.size()), 48'd0};
        rx = 64'd0;
        spi_cs = 1'b0;
        repeat (6) @(negedge pll_clk);
        for (int i = 7; i >= 0; i--) begin
            spi_si = cmd[i];
            repeat (H) @(negedge pll_clk);
            spi_clk = 1'b1;
            repeat (H) @(negedge pll_clk);
            spi_clk = 1'b0;
        end
        for (int i = 0; i < nbits + extra; i++) begin
            repeat (H) @(negedge pll_clk);
            if (i < nbits) rx = {rx[62:0], spi_so};
            else check("extra_bit", 64'(spi_so), 64'd0);
            spi_clk = 1'b1;
            if (cmd == 8'h01 && nbits == 64 && i == 63) pop_req_n++;
            if (cmd == 8'h02 && nbits == 16 && i == 15) clr_req_n++;
            if (cmd == 8'h01 && nbits == 64 && i == 63 && push_at_pop) begin
                repeat (2) @(posedge pll_clk);
                @(negedge pll_clk);
                id_valid    = 1'b1;
                trigger_id  = pp_id;
                hit_pattern = pp_hit;
                @(negedge pll_clk);
                id_valid = 1'b0;
                repeat (H - 3) @(negedge pll_clk);
            end else begin
                repeat (H) @(negedge pll_clk);
            end
            spi_clk = 1'b0;
        end
        check("rx_word", rx, exp >> (64 - nbits));
        if (!hold) begin
            repeat (H) @(negedge pll_clk);
            spi_cs = 1'b1;
            repeat (8) @(negedge pll_clk);
        end
    endtask

    logic [63:0] rx, rx20;

    initial begin
        reset = 1'b0; id_valid = 1'b0; trigger_id = '0; hit_pattern = '0;
        spi_clk = 1'b0; spi_cs = 1'b1; spi_si = 1'b0;
        repeat (3) @(negedge pll_clk);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_irq", 64'(interrupt), 64'd1);
        check("rst_so", 64'(spi_so), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge pll_clk);

        push(16'h1234, 24'hA5A5A5);
        push(16'hBEEF, 24'hA5A5A5);
        push(16'h0001, 24'hA5A5A5);
        check("count3", 64'(fifo_count), 64'd3);
        check("irq_low", 64'(interrupt), 64'd0);
        spi_frame(8'h01, 64, 0, 1'b0, rx);
        check("evt0", rx, 64'h1234_A5A5A5_000002);
        spi_frame(8'h01, 64, 0, 1'b0, rx);
        check("evt1", rx, 64'hBEEF_A5A5A5_000003);
        spi_frame(8'h01, 64, 2, 1'b0, rx);
        check("evt2", rx, 64'h0001_A5A5A5_000004);
        check("irq_high", 64'(interrupt), 64'd1);

        spi_frame(8'h01, 64, 2, 1'b0, rx);
        check("empty_read", rx, 64'd0);
        check("empty_count", 64'(fifo_count), 64'd0);

        spi_frame(8'h5A, 16, 0, 1'b0, rx);
        check("bad_cmd", rx, 64'd0);

        for (int i = 0; i < DEPTH + 5; i++) push(16'(i), 24'(i * 3));
        repeat (2) @(negedge pll_clk);
        check("ovf_set", 64'(overflow), 64'd1);
        check("full_count", 64'(fifo_count), 64'(DEPTH));
        spi_frame(8'h02, 16, 0, 1'b0, rx);
        check("status", rx, 64'h0510);
        check("ovf_clr", 64'(overflow), 64'd0);

        spi_frame(8'h01, 20, 0, 1'b0, rx20);
        check("abort_count", 64'(fifo_count), 64'(DEPTH));
        push_at_pop = 1'b1;
        pp_id       = 16'hCAFE;
        pp_hit      = 24'h123456;
        spi_frame(8'h01, 64, 0, 1'b0, rx);
        push_at_pop = 1'b0;
        check("same_evt", rx >> 44, rx20);
        check("head_evt", rx >> 24, 64'd0);
        check("pp_count", 64'(fifo_count), 64'(DEPTH));
        check("pp_ovf", 64'(overflow), 64'd0);

        reset = 1'b0;
        @(negedge pll_clk);
        reset = 1'b1;
        @(negedge pll_clk);
        for (int i = 0; i < 4; i++) push(16'h7000 + 16'(i), 24'h00FF00);
        repeat (3) @(negedge pll_clk);
        spi_frame(8'h01, 30, 0, 1'b1, rx);
        reset = 1'b0;
        @(negedge pll_clk);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_irq", 64'(interrupt), 64'd1);
        check("mid_rst_so", 64'(spi_so), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        spi_cs  = 1'b1;
        spi_clk = 1'b0;
        repeat (4) @(negedge pll_clk);
        reset = 1'b1;
        repeat (4) @(negedge pll_clk);
        spi_frame(8'h01, 64, 0, 1'b0, rx);
        check("post_rst_read", rx, 64'd0);
        check("post_rst_count", 64'(fifo_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trig_event_readout.md
# trig_event_readout

Event buffer and MCU readout stage directly downstream of the trigger-ID capture logic. Each completed trigger ID is stored in a FIFO together with the comparator hit pattern and a timestamp. The active-low `interrupt` pin is held low while events are pending. The MCU drains events over the SPI pins, which are oversampled in the `pll_clk` domain.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `pll_clk`  in  1  sole clock, 40 MHz (PLL output).
- `reset`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  one-cycle pulse: `trigger_id` holds a completed 16-bit ID.
- `trigger_id`  in  16  captured trigger ID, MSB first as shifted in.
- `hit_pattern`  in  24  synchronized comparator outputs (`c_input`), sampled on the `id_valid` cycle.
- `spi_clk`, `spi_cs`, `spi_si`  in  1  raw MCU SPI pins (mode 0; `spi_cs` active low).
- `spi_so`  out  1  SPI data out, registered.
- `interrupt`  out  1  active low; 0 while FIFO is non-empty.
- `fifo_count`  out  clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  1 while `drop_count` != 0.

## Operation
- Timestamp: a free-running 24-bit counter on `pll_clk`.
  - It is 0 out of reset and wraps 0xFFFFFF -> 0.
  - The value latched on an `id_valid` cycle is the counter value in that same cycle.
- Event word (64 b): {`trigger_id`[15:0], `hit_pattern`[23:0], timestamp[23:0]}, transmitted MSB first.
- Push on `id_valid`:
  - Not full: the entry is written.
  - Full: the event is dropped and the internal 8-bit `drop_count` increments, saturating at 255.
- SPI front end: the three SPI pins pass through 2-FF synchronizers plus edge detection.
- SPI frame: `spi_cs` falling starts the frame; the first 8 bits on `spi_si` (sampled on `spi_clk` rising) form a command. `spi_so` changes on `spi_clk` falling.
- Command 0x01 READ_EVENT:
  - At command decode, the FIFO head is peeked into a 64-bit shift register, without popping.
  - Bits are shifted out on the next 64 falling edges.
  - The pop occurs on the rising edge that completes bit 64.
  - If the FIFO was empty at decode, the shift register loads all zeros and no pop occurs.
- Command 0x02 READ_STATUS:
  - 16-bit response {`drop_count`[7:0], 3'b0, count[4:0]}; for `DEPTH` > 16 the count field carries the low 5 bits.
  - `drop_count` clears on the rising edge completing bit 16.
  - A drop in that same cycle leaves `drop_count` = 1.
- Any other command: `spi_so` = 0 for the rest of the frame, with no side effects.
- FSM states: IDLE -> CMD (8 bits) -> SHIFT_EVT or SHIFT_STAT or IGNORE -> DONE (wait for `spi_cs` high) -> IDLE.
  - `spi_cs` high in any state returns to IDLE in the next cycle.
  - The bit counter is reset on return to IDLE.
  - A pending pop or clear that has not completed is abandoned, so an aborted READ_EVENT loses no data.
- Extra clocks after frame completion return 0 on `spi_so`, with no second pop.
- Simultaneous push and pop:
  - Both take effect and the count is unchanged.
  - When full, the pop frees the slot and the push is accepted.
- Push to empty coinciding with a command decode: the peek sees the old (empty) state and returns zeros.
- `spi_so` = 0 whenever `spi_cs` is high.
- Reset: FIFO empty, `fifo_count` 0, `interrupt` 1, `spi_so` 0, `overflow` 0, timestamp 0, FSM in IDLE; the reset may arrive mid-frame.

## Timing
- Push -> `fifo_count` updates 1 cycle after `id_valid`; `interrupt` falls 2 cycles after `id_valid`.
- Pop -> `fifo_count` updates in the next cycle; `interrupt` rises the cycle after the count reaches 0.
- SPI pin edge -> detected edge: 3 `pll_clk` cycles. `spi_so` valid 4 cycles after the `spi_clk` falling pin edge.
- `spi_clk` high and low phases must each be ≥ 6 `pll_clk` cycles, i.e. ≤ 3.3 MHz; faster clocks are not supported.
- `spi_cs` falling to the first `spi_clk` rising: ≥ 4 cycles.
- Command decode to first data bit: the shift register is loaded before the falling edge that follows the 8th rising edge.

## Structure
- Package `trig_readout_pkg` holds:
  - command codes `CMD_READ_EVENT` = 8'h01 and `CMD_READ_STATUS` = 8'h02;
  - widths `ID_W` = 16, `HIT_W` = 24, `TS_W` = 24, `EVT_W` = 64;
  - the FSM state encoding.
- Sub-module `event_fifo`: synchronous single-clock FIFO with peek, push/pop/full/empty/count, async active-low reset, registered outputs. It maps to block RAM for `DEPTH` ≥ 64.
- The SPI pins reuse the existing `sync` module.

## Test plan
- Reset, then 3 pushes: IDs 0x1234, 0xBEEF, 0x0001 with hits 0xA5A5A5 at timestamps t0..t2 -> `fifo_count` 3, `interrupt` 0; three READ_EVENT frames return each 64-bit word exactly, in order. After the last frame `interrupt` = 1 within 2 cycles.
- READ_EVENT on empty FIFO -> 64 zero bits, `fifo_count` stays 0, `interrupt` stays 1.
- Push DEPTH+5 events, then READ_STATUS -> response 0x05 in `drop_count` and count = `DEPTH`[4:0]. `overflow` reads 1 before the read and 0 after the 16th bit.
- Raise `spi_cs` after 20 of 64 event bits -> `fifo_count` unchanged; the next full READ_EVENT returns the same event.
- `id_valid` on the cycle the pop completes with FIFO full -> new event accepted, count stays `DEPTH`, `drop_count` stays 0.
- Assert `reset` mid-SPI-frame with 4 events stored -> all outputs at reset values next cycle; the next frame decodes normally and returns zeros.
